// File: rtl/ysyx_220066_mem_resp_if.sv
// Core-side memory bus: fetch port and data port bundled
// between the core (master) and the memory responder (slave).
interface ysyx_220066_mem_resp_if;
  logic [63:0] pc_rd;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_error;
  logic        MemRd;
  logic        MemWr;
  logic [2:0]  MemOp;
  logic [63:0] addr;
  logic [63:0] data_Wr;
  logic [63:0] data_Rd;
  logic        data_Rd_valid;
  logic        data_Rd_error;

  modport master (
    output pc_rd, MemRd, MemWr, MemOp, addr, data_Wr,
    input  instr, instr_valid, instr_error,
    input  data_Rd, data_Rd_valid, data_Rd_error
  );

  modport slave (
    input  pc_rd, MemRd, MemWr, MemOp, addr, data_Wr,
    output instr, instr_valid, instr_error,
    output data_Rd, data_Rd_valid, data_Rd_error
  );
endinterface

// File: rtl/ysyx_220066_mem_resp.sv
// Shared 64-bit RAM serving a fetch port and a data port,
// each with its own programmable response latency.
module ysyx_220066_mem_resp #(
  parameter logic [63:0] BASE  = 64'h8000_0000,
  parameter int          DEPTH = 4096,
  parameter int          I_LAT = 1,
  parameter int          D_LAT = 2
) (
  input logic clk,
  input logic rst,
  ysyx_220066_mem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(I_LAT + 1);
  localparam int DW = $clog2(D_LAT + 1);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} st_e;

  logic [63:0] mem_q [DEPTH];

  st_e           i_st_q, i_st_d;
  logic [IW-1:0] i_cnt_q, i_cnt_d;
  logic [63:0]   i_pc_q, i_pc_d;
  logic [63:0]   i_cur, i_off, i_word;
  logic          i_err;
  logic [31:0]   i_data, i_instr_q;
  logic          i_err_q;

  // While waiting, the latched pc is served; otherwise the live one.
  assign i_cur  = (i_st_q == WAIT) ? i_pc_q : bus.pc_rd;
  assign i_off  = i_cur - BASE;
  assign i_word = mem_q[i_off[AW+2:3]];
  assign i_err  = (i_cur < BASE) || (i_off >= SPAN)
               || (i_cur[1:0] != 2'b00);
  assign i_data = i_err ? 32'd0
                : (i_cur[2] ? i_word[63:32] : i_word[31:0]);

  always_comb begin
    i_st_d  = i_st_q;
    i_cnt_d = i_cnt_q;
    i_pc_d  = i_pc_q;
    unique case (i_st_q)
      WAIT: begin
        if (bus.pc_rd != i_pc_q) begin
          i_pc_d  = bus.pc_rd;
          i_cnt_d = IW'(I_LAT - 1);
        end else if (i_cnt_q == IW'(1)) begin
          i_st_d = RESP;
        end else begin
          i_cnt_d = i_cnt_q - 1'b1;
        end
      end
      default: begin
        i_pc_d  = bus.pc_rd;
        i_cnt_d = IW'(I_LAT - 1);
        i_st_d  = (I_LAT == 1) ? RESP : WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_st_q    <= IDLE;
      i_cnt_q   <= '0;
      i_pc_q    <= '0;
      i_instr_q <= '0;
      i_err_q   <= 1'b0;
    end else begin
      i_st_q    <= i_st_d;
      i_cnt_q   <= i_cnt_d;
      i_pc_q    <= i_pc_d;
      i_instr_q <= (i_st_d == RESP) ? i_data : '0;
      i_err_q   <= (i_st_d == RESP) && i_err;
    end
  end

  assign bus.instr       = i_instr_q;
  assign bus.instr_valid = (i_st_q == RESP);
  assign bus.instr_error = i_err_q;

  st_e           d_st_q, d_st_d;
  logic [DW-1:0] d_cnt_q, d_cnt_d;
  logic [63:0]   d_a_q, d_a_d, d_wd_q, d_wd_d;
  logic [2:0]    d_op_q, d_op_d;
  logic          d_rd_q, d_rd_d, d_wr_q, d_wr_d;
  logic          d_req, d_hold;
  logic [63:0]   d_a, d_wd, d_off, d_word, d_sh, d_ext;
  logic [2:0]    d_op;
  logic          d_rd, d_wr, d_mis, d_err;
  logic [AW-1:0] d_idx;
  logic [7:0]    d_mask;
  logic [63:0]   d_rdata_q;
  logic          d_err_q;
  logic          w_en_q;
  logic [AW-1:0] w_idx_q;
  logic [7:0]    w_mask_q;
  logic [63:0]   w_data_q;

  assign d_req  = bus.MemRd || bus.MemWr;
  assign d_hold = (d_st_q == WAIT);
  assign d_a    = d_hold ? d_a_q  : bus.addr;
  assign d_wd   = d_hold ? d_wd_q : bus.data_Wr;
  assign d_op   = d_hold ? d_op_q : bus.MemOp;
  assign d_rd   = d_hold ? d_rd_q : bus.MemRd;
  assign d_wr   = d_hold ? d_wr_q : bus.MemWr;
  assign d_off  = d_a - BASE;
  assign d_idx  = d_off[AW+2:3];
  assign d_word = mem_q[d_idx];
  assign d_sh   = d_word >> {d_a[2:0], 3'b000};

  always_comb begin
    d_mis  = 1'b0;
    d_mask = 8'h01;
    unique case (d_op[1:0])
      2'b01: begin d_mis = d_a[0];      d_mask = 8'h03; end
      2'b10: begin d_mis = |d_a[1:0];   d_mask = 8'h0F; end
      2'b11: begin d_mis = |d_a[2:0];   d_mask = 8'hFF; end
      default: begin d_mis = 1'b0;      d_mask = 8'h01; end
    endcase
    d_mask = d_mask << d_a[2:0];
  end

  assign d_err = (d_a < BASE) || (d_off >= SPAN) || d_mis
              || (d_op == 3'b111) || (d_rd && d_wr);

  always_comb begin
    d_ext = d_sh;
    unique case (d_op)
      3'b000:  d_ext = {{56{d_sh[7]}},  d_sh[7:0]};
      3'b001:  d_ext = {{48{d_sh[15]}}, d_sh[15:0]};
      3'b010:  d_ext = {{32{d_sh[31]}}, d_sh[31:0]};
      3'b100:  d_ext = {56'd0, d_sh[7:0]};
      3'b101:  d_ext = {48'd0, d_sh[15:0]};
      3'b110:  d_ext = {32'd0, d_sh[31:0]};
      default: d_ext = d_sh;
    endcase
  end

  always_comb begin
    d_st_d  = d_st_q;
    d_cnt_d = d_cnt_q;
    d_a_d   = d_a_q;
    d_wd_d  = d_wd_q;
    d_op_d  = d_op_q;
    d_rd_d  = d_rd_q;
    d_wr_d  = d_wr_q;
    unique case (d_st_q)
      WAIT: begin
        if (!d_req) begin
          d_st_d = IDLE;
        end else if (d_cnt_q == DW'(1)) begin
          d_st_d = RESP;
        end else begin
          d_cnt_d = d_cnt_q - 1'b1;
        end
      end
      default: begin
        d_st_d = IDLE;
        if (d_req) begin
          d_a_d   = bus.addr;
          d_wd_d  = bus.data_Wr;
          d_op_d  = bus.MemOp;
          d_rd_d  = bus.MemRd;
          d_wr_d  = bus.MemWr;
          d_cnt_d = DW'(D_LAT - 1);
          d_st_d  = (D_LAT == 1) ? RESP : WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_st_q    <= IDLE;
      d_cnt_q   <= '0;
      d_a_q     <= '0;
      d_wd_q    <= '0;
      d_op_q    <= '0;
      d_rd_q    <= 1'b0;
      d_wr_q    <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
      w_en_q    <= 1'b0;
      w_idx_q   <= '0;
      w_mask_q  <= '0;
      w_data_q  <= '0;
    end else begin
      d_st_q  <= d_st_d;
      d_cnt_q <= d_cnt_d;
      d_a_q   <= d_a_d;
      d_wd_q  <= d_wd_d;
      d_op_q  <= d_op_d;
      d_rd_q  <= d_rd_d;
      d_wr_q  <= d_wr_d;
      if (d_st_d == RESP) begin
        d_rdata_q <= (d_err || d_wr) ? '0 : d_ext;
        d_err_q   <= d_err;
        w_en_q    <= d_wr && !d_err;
        w_idx_q   <= d_idx;
        w_mask_q  <= d_mask;
        w_data_q  <= d_wd << {d_a[2:0], 3'b000};
      end else begin
        d_rdata_q <= '0;
        d_err_q   <= 1'b0;
        w_en_q    <= 1'b0;
      end
    end
  end

  // Merge happens at commit so back-to-back writes see each other.
  always_ff @(posedge clk) begin
    if (rst && d_st_q == RESP && w_en_q) begin
      for (int b = 0; b < 8; b++) begin
        if (w_mask_q[b]) mem_q[w_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  assign bus.data_Rd       = d_rdata_q;
  assign bus.data_Rd_valid = (d_st_q == RESP);
  assign bus.data_Rd_error = d_err_q;
endmodule

// File: tb/tb_ysyx_220066_mem_resp.sv
// Directed bench for ysyx_220066_mem_resp: default-latency instance
// plus an I_LAT=3 instance for fetch-restart and data-abort cases.
module tb_ysyx_220066_mem_resp;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] LAST = 64'h8000_7FF8;
  localparam logic [63:0] TOP  = 64'h8000_8000;
  localparam logic [2:0] OB = 3'b000, OH = 3'b001, OW = 3'b010;
  localparam logic [2:0] OD = 3'b011, OBU = 3'b100, OHU = 3'b101;
  localparam logic [2:0] OWU = 3'b110, OBAD = 3'b111;
  localparam logic [63:0] W0 = 64'hDEADBEEF_CAFEF00D;

  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic [63:0] q;
  logic e;

  always #5 clk = ~clk;

  ysyx_220066_mem_resp_if b1 ();
  ysyx_220066_mem_resp_if b3 ();

  ysyx_220066_mem_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  ysyx_220066_mem_resp #(
    .BASE (BASE), .DEPTH (16), .I_LAT (3), .D_LAT (2)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  task automatic dreq(input bit u3, input logic rd, input logic wr,
                      input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] wd, output int lt,
                      output logic [63:0] rq, output logic re);
    int c;
    logic v;
    lt = -1; rq = '0; re = 1'b0; c = 0;
    if (u3) begin
      b3.MemRd = rd; b3.MemWr = wr; b3.MemOp = op;
      b3.addr = a; b3.data_Wr = wd;
    end else begin
      b1.MemRd = rd; b1.MemWr = wr; b1.MemOp = op;
      b1.addr = a; b1.data_Wr = wd;
    end
    while (lt < 0 && c < 8) begin
      c++;
      @(posedge clk); @(negedge clk);
      v = u3 ? b3.data_Rd_valid : b1.data_Rd_valid;
      if (v) begin
        lt = c;
        rq = u3 ? b3.data_Rd : b1.data_Rd;
        re = u3 ? b3.data_Rd_error : b1.data_Rd_error;
      end
    end
    b1.MemRd = 1'b0; b1.MemWr = 1'b0;
    b3.MemRd = 1'b0; b3.MemWr = 1'b0;
  endtask

  task automatic test_reset();
    dreq(0, 0, 1, OD, BASE, W0, lat, q, e);
    n_cmp++;
    if (lat !== 2 || e !== 1'b0 || q !== 64'd0) begin
      n_bad++;
      $display("FAIL preload_sd lat=%0d err=%b data=%h required 2/0/0", lat, e, q);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    b1.pc_rd = BASE; b1.MemRd = 1'b1; b1.MemOp = OD; b1.addr = BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({b1.instr_valid, b1.instr_error, b1.data_Rd_valid, b1.data_Rd_error} !== 4'b0
        || b1.instr !== 32'd0 || b1.data_Rd !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_outputs iv=%b ie=%b i=%h dv=%b de=%b d=%h required all 0",
               b1.instr_valid, b1.instr_error, b1.instr,
               b1.data_Rd_valid, b1.data_Rd_error, b1.data_Rd);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.instr_valid !== 1'b1 || b1.instr !== 32'hCAFEF00D || b1.instr_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_fetch iv=%b i=%h ie=%b required 1/cafef00d/0",
               b1.instr_valid, b1.instr, b1.instr_error);
    end
    n_cmp++;
    if (b1.data_Rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data_early dv=%b required 0", b1.data_Rd_valid);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.data_Rd_valid !== 1'b1 || b1.data_Rd !== W0 || b1.data_Rd_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data dv=%b d=%h de=%b required 1/%h/0",
               b1.data_Rd_valid, b1.data_Rd, b1.data_Rd_error, W0);
    end
    b1.MemRd = 1'b0;
  endtask

  task automatic test_reset_abort();
    dreq(0, 0, 1, OD, BASE + 16, 64'h01234567_89ABCDEF, lat, q, e);
    b1.MemWr = 1'b1; b1.MemOp = OD; b1.addr = BASE + 16;
    b1.data_Wr = 64'hFFFF0000_FFFF0000;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.data_Rd_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_wr_ack dv=%b required 1", b1.data_Rd_valid);
    end
    rst = 1'b0; b1.MemWr = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    dreq(0, 1, 0, OD, BASE + 16, 64'd0, lat, q, e);
    n_cmp++;
    if (lat !== 2 || q !== 64'h01234567_89ABCDEF) begin
      n_bad++;
      $display("FAIL reset_no_commit lat=%0d data=%h required 2/0123456789abcdef", lat, q);
    end
  endtask

  task automatic test_store_load();
    dreq(0, 0, 1, OD, BASE + 8, 64'h11223344_55667788, lat, q, e);
    n_cmp++;
    if (lat !== 2 || e !== 1'b0 || q !== 64'd0) begin
      n_bad++;
      $display("FAIL sd_ack lat=%0d err=%b data=%h required 2/0/0", lat, e, q);
    end
    dreq(0, 1, 0, OB, BASE + 15, 64'd0, lat, q, e);
    n_cmp++;
    if (lat !== 2 || e !== 1'b0 || q !== 64'h11) begin
      n_bad++;
      $display("FAIL lb_15 lat=%0d err=%b data=%h required 2/0/11", lat, e, q);
    end
    dreq(0, 1, 0, OBU, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'h88) begin
      n_bad++; $display("FAIL lbu_8 data=%h required 88", q);
    end
    dreq(0, 1, 0, OB, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'hFFFFFFFF_FFFFFF88) begin
      n_bad++; $display("FAIL lb_8 data=%h required ffffffffffffff88", q);
    end
    dreq(0, 1, 0, OHU, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'h7788) begin
      n_bad++; $display("FAIL lhu_8 data=%h required 7788", q);
    end
    dreq(0, 1, 0, OW, BASE + 12, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'h11223344) begin
      n_bad++; $display("FAIL lw_12 data=%h required 11223344", q);
    end
    dreq(0, 0, 1, OW, BASE + 20, 64'h00000000_F0E1D2C3, lat, q, e);
    dreq(0, 1, 0, OW, BASE + 20, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'hFFFFFFFF_F0E1D2C3) begin
      n_bad++; $display("FAIL lw_neg data=%h required fffffffff0e1d2c3", q);
    end
    dreq(0, 1, 0, OWU, BASE + 20, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'hF0E1D2C3) begin
      n_bad++; $display("FAIL lwu data=%h required f0e1d2c3", q);
    end
    dreq(0, 1, 0, OH, BASE + 20, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'hFFFFFFFF_FFFFD2C3) begin
      n_bad++; $display("FAIL lh_neg data=%h required ffffffffffffd2c3", q);
    end
    dreq(0, 1, 0, OHU, BASE + 22, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'hF0E1) begin
      n_bad++; $display("FAIL lhu_22 data=%h required f0e1", q);
    end
    dreq(0, 1, 0, OD, BASE + 16, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'hF0E1D2C3_89ABCDEF) begin
      n_bad++; $display("FAIL ld_16 data=%h required f0e1d2c389abcdef", q);
    end
  endtask

  task automatic test_byte_merge();
    dreq(0, 0, 1, OB, BASE + 10, 64'hAB, lat, q, e);
    dreq(0, 1, 0, OD, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'h11223344_55AB7788) begin
      n_bad++; $display("FAIL sb_merge data=%h required 1122334455ab7788", q);
    end
    dreq(0, 0, 1, OH, BASE + 12, 64'hFFFFFFFF_FFFFBEEF, lat, q, e);
    dreq(0, 1, 0, OD, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'h1122BEEF_55AB7788) begin
      n_bad++; $display("FAIL sh_merge data=%h required 1122beef55ab7788", q);
    end
  endtask

  task automatic test_errors();
    dreq(0, 1, 0, OW, BASE + 2, 64'd0, lat, q, e);
    n_cmp++;
    if (lat !== 2 || e !== 1'b1 || q !== 64'd0) begin
      n_bad++; $display("FAIL lw_misalign lat=%0d err=%b data=%h required 2/1/0", lat, e, q);
    end
    dreq(0, 1, 0, OD, BASE + 4, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL ld_misalign err=%b required 1", e); end
    dreq(0, 1, 0, OH, BASE + 1, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL lh_misalign err=%b required 1", e); end
    dreq(0, 1, 0, OBAD, BASE, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b1 || q !== 64'd0) begin
      n_bad++; $display("FAIL op111 err=%b data=%h required 1/0", e, q);
    end
    dreq(0, 1, 1, OD, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL rd_and_wr err=%b required 1", e); end
    dreq(0, 0, 1, OW, BASE + 9, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL sw_misalign err=%b required 1", e); end
    dreq(0, 0, 1, OD, LAST, 64'h5A5A5A5A_A5A5A5A5, lat, q, e);
    n_cmp++;
    if (e !== 1'b0) begin n_bad++; $display("FAIL sd_last err=%b required 0", e); end
    dreq(0, 0, 1, OD, BASE - 8, 64'h1234, lat, q, e);
    n_cmp++;
    if (lat !== 2 || e !== 1'b1) begin
      n_bad++; $display("FAIL sd_below lat=%0d err=%b required 2/1", lat, e);
    end
    dreq(0, 0, 1, OD, TOP, 64'h5678, lat, q, e);
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL sd_top err=%b required 1", e); end
    dreq(0, 1, 0, OD, LAST, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b0 || q !== 64'h5A5A5A5A_A5A5A5A5) begin
      n_bad++; $display("FAIL ld_last err=%b data=%h required 0/5a5a5a5aa5a5a5a5", e, q);
    end
    dreq(0, 1, 0, OD, BASE, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== W0) begin n_bad++; $display("FAIL ld_word0 data=%h required %h", q, W0); end
    dreq(0, 1, 0, OD, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (q !== 64'h1122BEEF_55AB7788) begin
      n_bad++; $display("FAIL ld_word1 data=%h required 1122beef55ab7788", q);
    end
    dreq(0, 1, 0, OBU, TOP - 1, 64'd0, lat, q, e);
    n_cmp++;
    if (e !== 1'b0 || q !== 64'h5A) begin
      n_bad++; $display("FAIL lbu_topbyte err=%b data=%h required 0/5a", e, q);
    end
    b1.pc_rd = BASE + 2;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.instr_valid !== 1'b1 || b1.instr_error !== 1'b1 || b1.instr !== 32'd0) begin
      n_bad++; $display("FAIL pc_misalign iv=%b ie=%b i=%h required 1/1/0",
                        b1.instr_valid, b1.instr_error, b1.instr);
    end
    b1.pc_rd = BASE - 4;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.instr_error !== 1'b1) begin
      n_bad++; $display("FAIL pc_below ie=%b required 1", b1.instr_error);
    end
    b1.pc_rd = TOP;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.instr_error !== 1'b1) begin
      n_bad++; $display("FAIL pc_top ie=%b required 1", b1.instr_error);
    end
    b1.pc_rd = LAST + 4;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (b1.instr_error !== 1'b0 || b1.instr !== 32'h5A5A5A5A) begin
      n_bad++; $display("FAIL pc_last ie=%b i=%h required 0/5a5a5a5a",
                        b1.instr_error, b1.instr);
    end
    b1.pc_rd = BASE;
  endtask

  task automatic test_abort_restart();
    int c, nv, fc;
    logic [31:0] fi;
    logic fe;
    dreq(1, 0, 1, OD, BASE, 64'hA1A2A3A4_B1B2B3B4, lat, q, e);
    dreq(1, 0, 1, OD, BASE + 8, 64'hC1C2C3C4_D1D2D3D4, lat, q, e);
    n_cmp++;
    if (lat !== 2 || e !== 1'b0) begin
      n_bad++; $display("FAIL lat3_preload lat=%0d err=%b required 2/0", lat, e);
    end
    c = 0;
    while (b3.instr_valid !== 1'b1 && c < 8) begin
      c++; @(posedge clk); @(negedge clk);
    end
    n_cmp++;
    if (b3.instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL lat3_first_fetch iv=%b required 1", b3.instr_valid);
    end
    b3.pc_rd = BASE + 8;
    @(posedge clk); @(negedge clk);
    b3.pc_rd = BASE + 12;
    nv = 0; fc = 0; fi = '0; fe = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (b3.instr_valid === 1'b1) begin
        nv++;
        if (fc == 0) begin fc = k; fi = b3.instr; fe = b3.instr_error; end
      end
    end
    n_cmp++;
    if (nv !== 1 || fc !== 3 || fi !== 32'hC1C2C3C4 || fe !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_restart count=%0d at=%0d instr=%h err=%b required 1/3/c1c2c3c4/0",
               nv, fc, fi, fe);
    end
    b3.MemWr = 1'b1; b3.MemOp = OD; b3.addr = BASE + 8;
    b3.data_Wr = 64'h0;
    @(posedge clk); @(negedge clk);
    b3.MemWr = 1'b0;
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (b3.data_Rd_valid === 1'b1) nv++;
    end
    n_cmp++;
    if (nv !== 0) begin
      n_bad++; $display("FAIL data_abort_ack count=%0d required 0", nv);
    end
    dreq(1, 1, 0, OD, BASE + 8, 64'd0, lat, q, e);
    n_cmp++;
    if (lat !== 2 || q !== 64'hC1C2C3C4_D1D2D3D4) begin
      n_bad++; $display("FAIL data_abort_nowrite lat=%0d data=%h required 2/c1c2c3c4d1d2d3d4",
                        lat, q);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h33333333; exp_i[1] = 32'h44444444;
    exp_i[2] = 32'h55555555; exp_i[3] = 32'h66666666;
    dreq(0, 0, 1, OD, BASE + 32, 64'h44444444_33333333, lat, q, e);
    dreq(0, 0, 1, OD, BASE + 40, 64'h66666666_55555555, lat, q, e);
    @(posedge clk); @(negedge clk);
    b1.pc_rd = BASE + 32;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (b1.instr_valid !== 1'b1 || b1.instr !== exp_i[k]) begin
        n_bad++; $display("FAIL stream_%0d iv=%b i=%h required 1/%h",
                          k, b1.instr_valid, b1.instr, exp_i[k]);
      end
      b1.pc_rd = b1.pc_rd + 64'd4;
    end
  endtask

  initial begin
    rst = 1'b0;
    b1.pc_rd = BASE; b1.MemRd = 1'b0; b1.MemWr = 1'b0; b1.MemOp = 3'b0;
    b1.addr = '0; b1.data_Wr = '0;
    b3.pc_rd = BASE; b3.MemRd = 1'b0; b3.MemWr = 1'b0; b3.MemOp = 3'b0;
    b3.addr = '0; b3.data_Wr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_reset_abort();
    test_store_load();
    test_byte_merge();
    test_errors();
    test_abort_restart();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
